// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate byte cache: 8 blocks x 4 bytes.
// Refills and write-backs move whole 32-bit blocks over a busy-wait memory handshake.
module data_cache (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic [7:0]  READDATA,
  output logic        BUSYWAIT,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
);

  localparam int unsigned NUM_BLOCKS = 8;
  localparam int unsigned TAG_W      = 3;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned OFF_W      = 2;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned BLOCK_W    = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    FETCH,
    UPDATE
  } state_e;

  state_e                  state_q, state_d;
  logic                    first_q;
  logic [BLOCK_W-1:0]      data_q [NUM_BLOCKS];
  logic [TAG_W-1:0]        tag_q  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0]   valid_q;
  logic [NUM_BLOCKS-1:0]   dirty_q;
  logic [TAG_W-1:0]        tag_lat_q;
  logic [IDX_W-1:0]        idx_lat_q;

  logic [TAG_W-1:0]        tag_c;
  logic [IDX_W-1:0]        idx_c;
  logic [OFF_W-1:0]        off_c;
  logic                    hit_c;
  logic                    mem_done_c;
  logic                    wr_hit_c;
  logic                    fill_c;
  logic                    miss_c;

  assign tag_c      = ADDRESS[7:5];
  assign idx_c      = ADDRESS[4:2];
  assign off_c      = ADDRESS[1:0];
  assign hit_c      = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
  // The issue cycle never completes, so a stale low MEM_BUSYWAIT is ignored.
  assign mem_done_c = !first_q && !MEM_BUSYWAIT;

  // Next-state, CPU-side and memory-side outputs
  always_comb begin
    state_d       = state_q;
    READDATA      = 8'h00;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = 6'h00;
    MEM_WRITEDATA = 32'h0;
    wr_hit_c      = 1'b0;
    fill_c        = 1'b0;
    miss_c        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (READ || WRITE) begin
          if (hit_c) begin
            wr_hit_c = WRITE;
            if (READ) READDATA = data_q[idx_c][{off_c, 3'b000} +: BYTE_W];
          end else begin
            BUSYWAIT = 1'b1;
            miss_c   = 1'b1;
            state_d  = (valid_q[idx_c] && dirty_q[idx_c]) ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[idx_lat_q], idx_lat_q};
        MEM_WRITEDATA = data_q[idx_lat_q];
        if (mem_done_c) state_d = FETCH;
      end
      FETCH: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {tag_lat_q, idx_lat_q};
        if (mem_done_c) begin
          fill_c  = 1'b1;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        BUSYWAIT = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (RESET) BUSYWAIT = 1'b0;
  end

  // Control state, line status bits and miss latch
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
      if (miss_c) begin
        tag_lat_q <= tag_c;
        idx_lat_q <= idx_c;
      end
      if (wr_hit_c) dirty_q[idx_c] <= 1'b1;
      if (fill_c) begin
        valid_q[idx_lat_q] <= 1'b1;
        dirty_q[idx_lat_q] <= 1'b0;
      end
    end
  end

  // Data and tag arrays carry no reset; valid bits qualify them
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (wr_hit_c) data_q[idx_c][{off_c, 3'b000} +: BYTE_W] <= WRITEDATA;
      if (fill_c) begin
        data_q[idx_lat_q] <= MEM_READDATA;
        tag_q[idx_lat_q]  <= tag_lat_q;
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: vector table for single-access traffic plus
// hand sequences for reset, write-back/refill and reset during a refill.
module tb_data_cache;

  localparam int MEM_N = 5;

  logic        CLK;
  logic        RESET;
  logic        READ;
  logic        WRITE;
  logic [7:0]  ADDRESS;
  logic [7:0]  WRITEDATA;
  logic [7:0]  READDATA;
  logic        BUSYWAIT;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  data_cache dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .READ         (READ),
    .WRITE        (WRITE),
    .ADDRESS      (ADDRESS),
    .WRITEDATA    (WRITEDATA),
    .READDATA     (READDATA),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_WRITE    (MEM_WRITE),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory model: busy for MEM_N cycles per transfer, one recovery cycle
  // when a new request follows a completed one back to back.
  logic [31:0] mem [64];
  int          mcnt;
  logic        mrec;
  logic        mem_load;
  logic        mreq;

  assign mreq         = MEM_READ | MEM_WRITE;
  assign MEM_BUSYWAIT = mreq && (mrec || (mcnt < MEM_N));
  assign MEM_READDATA = mem[MEM_ADDRESS];

  always @(posedge CLK) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) mem[i] <= {4{8'(i)}};
      mem[1] <= 32'hDDCCBBAA;
      mem[9] <= 32'h44332211;
      mcnt   <= 0;
      mrec   <= 1'b0;
    end else if (RESET) begin
      mcnt <= 0;
      mrec <= 1'b0;
    end else if (mreq && !MEM_BUSYWAIT) begin
      if (MEM_WRITE) mem[MEM_ADDRESS] <= MEM_WRITEDATA;
      mcnt <= 0;
      mrec <= 1'b1;
    end else if (mreq && mrec) begin
      mcnt <= 0;
      mrec <= 1'b0;
    end else if (mreq) begin
      mcnt <= mcnt + 1;
    end else begin
      mcnt <= 0;
      mrec <= 1'b0;
    end
  end

  // Memory-side monitor
  int          wb_cyc = 0;
  int          rd_cyc = 0;
  int          wb_unstable = 0;
  logic [5:0]  wb_addr = '0;
  logic [5:0]  rd_addr = '0;
  logic [31:0] wb_data = '0;
  logic        prev_wr = 1'b0;

  always @(negedge CLK) begin
    #2;
    if (MEM_WRITE) begin
      if (prev_wr && ((MEM_ADDRESS !== wb_addr) || (MEM_WRITEDATA !== wb_data)))
        wb_unstable++;
      wb_cyc++;
      wb_addr = MEM_ADDRESS;
      wb_data = MEM_WRITEDATA;
    end
    if (MEM_READ) begin
      rd_cyc++;
      rd_addr = MEM_ADDRESS;
    end
    prev_wr = MEM_WRITE;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Present one request and hold it until the cache stops stalling.
  task automatic do_access(input logic rd, input logic wr, input logic [7:0] a,
                           input logic [7:0] wd, output int stalls,
                           output logic [7:0] rdata);
    bit done;
    @(negedge CLK);
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = wd;
    stalls = 0;
    rdata  = 8'hXX;
    done   = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!BUSYWAIT) begin
        rdata = READDATA;
        done  = 1;
        break;
      end
      stalls++;
      @(negedge CLK);
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL access_timeout addr=%0h: BUSYWAIT still high after 100 cycles", a);
    end
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wd;
    logic       chk_rd;
    logic [7:0] exp_rd;
    int         exp_stall;
  } vec_t;

  vec_t vec [11];

  task automatic run_vec(input int i);
    int         st;
    logic [7:0] rdv;
    do_access(vec[i].rd, vec[i].wr, vec[i].addr, vec[i].wd, st, rdv);
    check($sformatf("vec%0d_stall", i), 32'(st), 32'(vec[i].exp_stall));
    if (vec[i].chk_rd) check($sformatf("vec%0d_readdata", i), 32'(rdv), 32'(vec[i].exp_rd));
  endtask

  initial begin
    int         st;
    logic [7:0] rdv;
    int         wb0, rd0, un0;

    //          rd    wr    addr   wd     chk   exp    stall
    vec[0]  = '{1'b0, 1'b1, 8'h06, 8'h5A, 1'b1, 8'h00, 0};
    vec[1]  = '{1'b1, 1'b0, 8'h06, 8'h00, 1'b1, 8'h5A, 0};
    vec[2]  = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 8'hAA, 0};
    vec[3]  = '{1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 8'hBB, 0};
    vec[4]  = '{1'b1, 1'b0, 8'h06, 8'h00, 1'b1, 8'h5A, 0};
    vec[5]  = '{1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 8'hDD, 0};
    vec[6]  = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 8'hAA, MEM_N + 3};
    vec[7]  = '{1'b1, 1'b1, 8'h04, 8'h77, 1'b0, 8'h00, 0};
    vec[8]  = '{1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 8'h77, 0};
    vec[9]  = '{1'b1, 1'b0, 8'h07, 8'h00, 1'b1, 8'hDD, 0};
    vec[10] = '{1'b1, 1'b0, 8'h06, 8'h00, 1'b1, 8'h5A, 0};

    // Reset with a pending miss: stall must be suppressed
    mem_load = 1'b1;
    RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h05; WRITEDATA = 8'h00;
    @(negedge CLK);
    #1;
    check("reset_busywait",  32'(BUSYWAIT), 32'h0);
    check("reset_mem_read",  32'(MEM_READ), 32'h0);
    check("reset_mem_write", 32'(MEM_WRITE), 32'h0);
    check("reset_mem_addr",  32'(MEM_ADDRESS), 32'h0);
    check("reset_mem_wdata", MEM_WRITEDATA, 32'h0);
    check("reset_readdata",  32'(READDATA), 32'h0);
    mem_load = 1'b0;
    READ = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;

    // Clean miss on invalid block
    wb0 = wb_cyc; rd0 = rd_cyc;
    do_access(1'b1, 1'b0, 8'h05, 8'h00, st, rdv);
    check("clean_miss_stall", 32'(st), 32'(MEM_N + 3));
    check("clean_miss_data",  32'(rdv), 32'hBB);
    check("clean_miss_fetch_cycles", 32'(rd_cyc - rd0), 32'(MEM_N + 1));
    check("clean_miss_fetch_addr", 32'(rd_addr), 32'h01);
    check("clean_miss_no_wb", 32'(wb_cyc - wb0), 32'h0);

    // Write hit and back-to-back read hits
    wb0 = wb_cyc; rd0 = rd_cyc;
    for (int i = 0; i <= 5; i++) run_vec(i);
    check("hits_no_mem_traffic", 32'((wb_cyc - wb0) + (rd_cyc - rd0)), 32'h0);

    // Dirty conflict miss: write-back then refill
    wb0 = wb_cyc; rd0 = rd_cyc; un0 = wb_unstable;
    do_access(1'b1, 1'b0, 8'h26, 8'h00, st, rdv);
    check("dirty_miss_stall", 32'(st), 32'(2 * MEM_N + 5));
    check("dirty_miss_data",  32'(rdv), 32'h33);
    check("dirty_miss_wb_addr", 32'(wb_addr), 32'h01);
    check("dirty_miss_wb_data", wb_data, 32'hDD5ABBAA);
    check("dirty_miss_wb_cycles", 32'(wb_cyc - wb0), 32'(MEM_N + 1));
    check("dirty_miss_wb_stable", 32'(wb_unstable - un0), 32'h0);
    check("dirty_miss_fetch_addr", 32'(rd_addr), 32'h09);
    check("dirty_miss_fetch_cycles", 32'(rd_cyc - rd0), 32'(MEM_N + 2));

    // Refill of written-back block, READ+WRITE treated as write
    for (int i = 6; i <= 10; i++) run_vec(i);

    // Reset in the middle of a refill
    @(negedge CLK);
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h09;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check("midfetch_mem_read", 32'(MEM_READ), 32'h1);
    check("midfetch_mem_addr", 32'(MEM_ADDRESS), 32'h02);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check("midfetch_reset_busywait", 32'(BUSYWAIT), 32'h0);
    @(negedge CLK);
    #1;
    check("after_reset_mem_read", 32'(MEM_READ), 32'h0);
    check("after_reset_busywait", 32'(BUSYWAIT), 32'h0);
    READ = 1'b0;
    RESET = 1'b0;

    do_access(1'b1, 1'b0, 8'h09, 8'h00, st, rdv);
    check("post_reset_miss_stall", 32'(st), 32'(MEM_N + 3));
    check("post_reset_miss_data",  32'(rdv), 32'h02);
    do_access(1'b1, 1'b0, 8'h04, 8'h00, st, rdv);
    check("post_reset_dirty_dropped_stall", 32'(st), 32'(MEM_N + 3));
    check("post_reset_dirty_dropped_data",  32'(rdv), 32'hAA);

    @(negedge CLK);
    READ = 1'b0; WRITE = 1'b0;
    @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
